multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle sequencer for the RV32I datapath. It consumes the opcode and funct3 fields produced by InstructionDecoder from the instruction register and drives the datapath strobes: IR load, PC update, memory requests, register-file write and writeback select. It sits between the instruction/data memory ports and the decoder, ALU and register file. It also flags illegal or unsupported instructions and counts retired instructions.

## Interface
Parameters:
- INSTRET_WIDTH, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  from InstructionDecoder, instr[6:0]
- funct3  in  3  from InstructionDecoder, instr[14:12]
- branch_taken  in  1  branch comparator result, valid in EXECUTE
- imem_ready  in  1  instruction memory accepts/returns fetch this cycle
- dmem_ready  in  1  data memory completes access this cycle
- imem_req  out  1  fetch request
- ir_write  out  1  load instruction register
- dmem_req  out  1  data access request
- dmem_write  out  1  store qualifier for dmem_req
- alu_src_b  out  1  0 = rs2, 1 = imm
- rf_write  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm (LUI)
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 (rs1+imm)&~1 (JALR)
- trap  out  1  sticky illegal/system-instruction flag
- state  out  3  current state encoding, debug
- instret  out  INSTRET_WIDTH  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5. Codes 6–7 go to TRAP.
- FETCH:
  - imem_req=1.
  - On imem_ready, assert ir_write=1 and go to DECODE. Otherwise hold.
- DECODE: legality check on opcode/funct3, then go to EXECUTE or TRAP. Illegal means any of:
  - opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
  - LOAD funct3 not in {000, 001, 010, 100, 101}.
  - STORE funct3 > 010.
  - BRANCH funct3 in {010, 011}.
  - JALR funct3 ≠ 000.
- EXECUTE: alu_src_b=1 for OP-IMM/LOAD/STORE/JALR, else 0.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR go to WB.
  - LOAD, STORE go to MEM.
  - BRANCH: pc_write=1, pc_src = branch_taken ? 01 : 00, then FETCH.
  - MISC-MEM (FENCE treated as NOP): pc_write=1, pc_src=00, then FETCH.
  - SYSTEM (ECALL/EBREAK/CSR, unsupported) goes to TRAP.
- MEM:
  - dmem_req=1, dmem_write=1 for STORE. Held until dmem_ready.
  - Store: on dmem_ready, pc_write=1, pc_src=00, then FETCH.
  - Load: on dmem_ready, go to WB.
- WB:
  - rf_write=1 and pc_write=1.
  - wb_sel: LOAD 01, JAL/JALR 10, LUI 11, else 00.
  - pc_src: JAL 01, JALR 10, else 00.
  - Then FETCH.
- TRAP: trap=1, all other strobes 0. Held until reset.
- instret increments by 1 on every cycle with pc_write=1 and wraps modulo 2^INSTRET_WIDTH.
- opcode/funct3 are read only in DECODE, EXECUTE, MEM and WB. IR is stable after ir_write.

## Timing
- All outputs are decoded combinationally from the state register, opcode, funct3 and the ready/branch inputs.
- State and instret are registered.
- Reset is sampled on the clk rising edge.
  - While reset=1, every strobe output is forced 0 and trap=0.
  - On the edge: state←FETCH, instret←0.
  - The first imem_req appears in the first cycle with reset=0.
- Reset mid-operation (any state, including TRAP or a MEM wait) aborts the instruction. No pc_write or rf_write occurs in the reset cycle.
- Minimum latencies with ready asserted immediately:
  - BRANCH/FENCE: 3 cycles
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- Each cycle of ready=0 in FETCH or MEM adds one cycle.
- Handshakes:
  - imem_req and dmem_req stay high and constant until their ready is seen.
  - A ready input outside FETCH or MEM is ignored.
- A pc_write never coincides with ir_write. At most one pc_write per instruction.

## Structure
- Package rv32i_pkg holds:
  - RV32I opcode localparams (7-bit).
  - State encoding.
  - pc_src and wb_sel encodings.
  - Shared with InstructionDecoder and the datapath.
- One natural sub-module: rv32i_legality_check, a combinational opcode/funct3 → legal flag plus instruction class. It is reused later by the pipelined core.
- FSM and instret counter live in the top module.

## Test plan
- ADD (opcode 0110011), imem_ready and dmem_ready always 1:
  - States 0→1→2→4→0.
  - rf_write=1, wb_sel=00, pc_src=00 in WB.
  - instret 0→1 after 4 cycles.
- LW (0000011, funct3 010), dmem_ready low for 3 MEM cycles:
  - dmem_req=1 and dmem_write=0 held 4 cycles.
  - WB has wb_sel=01. Total 8 cycles.
- BEQ (1100011, funct3 000):
  - branch_taken=1 gives pc_src=01, pc_write in cycle 3.
  - branch_taken=0 gives pc_src=00.
  - No rf_write.
- JALR (1100111, funct3 000): WB shows wb_sel=10, pc_src=10, rf_write=1, alu_src_b=1 in EXECUTE.
- Illegal instructions:
  - opcode 0000000 → TRAP after DECODE: trap=1 and all strobes 0 for 10 cycles.
  - STORE funct3 011 → TRAP.
  - ECALL (1110011) → TRAP from EXECUTE.
- Reset during MEM wait of SW: next cycle state=0, instret=0, no pc_write. Run 2^INSTRET_WIDTH retirements with INSTRET_WIDTH=4 → wraps to 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, sequencer state encoding, datapath select
// encodings and instruction classes used by the control unit and decoder.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int NUM_OPCODES = 11;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JALR   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_IMM  = 2'b11
    } wb_sel_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OP_IMM,
        CLS_OP,
        CLS_FENCE,
        CLS_SYSTEM
    } instr_class_t;

    // ALU operand B comes from the immediate for address and I-type arithmetic.
    function automatic logic cls_uses_imm(input instr_class_t cls);
        return (cls == CLS_OP_IMM) || (cls == CLS_LOAD) ||
               (cls == CLS_STORE)  || (cls == CLS_JALR);
    endfunction

    function automatic wb_sel_t cls_wb_sel(input instr_class_t cls);
        case (cls)
            CLS_LOAD:          return WB_SEL_LOAD;
            CLS_JAL, CLS_JALR: return WB_SEL_PC4;
            CLS_LUI:           return WB_SEL_IMM;
            default:           return WB_SEL_ALU;
        endcase
    endfunction

    function automatic pc_src_t cls_wb_pc_src(input instr_class_t cls);
        case (cls)
            CLS_JAL:  return PC_SRC_BRANCH;
            CLS_JALR: return PC_SRC_JALR;
            default:  return PC_SRC_PLUS4;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_legality_check.sv
// Combinational opcode/funct3 classifier: reports whether the instruction is
// a supported RV32I encoding and which execution class it belongs to.
module rv32i_legality_check
    import rv32i_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output logic         legal,
    output instr_class_t cls
);

    localparam logic [6:0] OPC_TABLE [NUM_OPCODES] = '{
        OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
        OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM
    };
    localparam instr_class_t CLS_TABLE [NUM_OPCODES] = '{
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
        CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_FENCE, CLS_SYSTEM
    };

    // Bit n set means funct3 == n is a valid width/condition for that class.
    localparam logic [7:0] LOAD_F3_MASK   = 8'b0011_0111;
    localparam logic [7:0] STORE_F3_MASK  = 8'b0000_0111;
    localparam logic [7:0] BRANCH_F3_MASK = 8'b1111_0011;
    localparam logic [7:0] JALR_F3_MASK   = 8'b0000_0001;

    logic [NUM_OPCODES-1:0] opc_hit;
    instr_class_t           base_cls;
    logic                   f3_ok;

    generate
        for (genvar gi = 0; gi < NUM_OPCODES; gi++) begin : g_opc_match
            assign opc_hit[gi] = (opcode == OPC_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        base_cls = CLS_ILLEGAL;
        for (int i = 0; i < NUM_OPCODES; i++) begin
            if (opc_hit[i]) begin
                base_cls = CLS_TABLE[i];
            end
        end
    end

    always_comb begin
        case (base_cls)
            CLS_LOAD:   f3_ok = LOAD_F3_MASK[funct3];
            CLS_STORE:  f3_ok = STORE_F3_MASK[funct3];
            CLS_BRANCH: f3_ok = BRANCH_F3_MASK[funct3];
            CLS_JALR:   f3_ok = JALR_F3_MASK[funct3];
            default:    f3_ok = 1'b1;
        endcase
    end

    assign legal = (base_cls != CLS_ILLEGAL) && f3_ok;
    assign cls   = legal ? base_cls : CLS_ILLEGAL;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB per
// instruction, drives datapath strobes, traps on illegal/system opcodes.
module multicycle_control_unit
    import rv32i_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     branch_taken,
    input  logic                     imem_ready,
    input  logic                     dmem_ready,
    output logic                     imem_req,
    output logic                     ir_write,
    output logic                     dmem_req,
    output logic                     dmem_write,
    output logic                     alu_src_b,
    output logic                     rf_write,
    output logic [1:0]               wb_sel,
    output logic                     pc_write,
    output logic [1:0]               pc_src,
    output logic                     trap,
    output logic [2:0]               state,
    output logic [INSTRET_WIDTH-1:0] instret
);

    state_t                   state_reg;
    state_t                   state_next;
    logic [INSTRET_WIDTH-1:0] instret_reg;
    logic [INSTRET_WIDTH-1:0] instret_next;
    logic                     legal;
    instr_class_t             cls;

    rv32i_legality_check u_legality (
        .opcode (opcode),
        .funct3 (funct3),
        .legal  (legal),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            instret_reg <= instret_next;
        end
    end

    // Every pc_write marks exactly one retired instruction.
    assign instret_next = pc_write ? instret_reg + INSTRET_WIDTH'(1) : instret_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = legal ? ST_EXECUTE : ST_TRAP;
            end
            ST_EXECUTE: begin
                case (cls)
                    CLS_OP, CLS_OP_IMM, CLS_LUI,
                    CLS_AUIPC, CLS_JAL, CLS_JALR: state_next = ST_WB;
                    CLS_LOAD, CLS_STORE:          state_next = ST_MEM;
                    CLS_BRANCH, CLS_FENCE:        state_next = ST_FETCH;
                    default:                      state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_next = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_TRAP;
            end
        endcase
    end

    // While reset is held every strobe stays low, so an aborted instruction
    // cannot retire or write the register file in the reset cycle.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_write = 1'b0;
        alu_src_b  = 1'b0;
        rf_write   = 1'b0;
        wb_sel     = WB_SEL_ALU;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PLUS4;
        trap       = 1'b0;
        if (!reset) begin
            case (state_reg)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                ST_EXECUTE: begin
                    alu_src_b = cls_uses_imm(cls);
                    if (cls == CLS_BRANCH) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                    end else if (cls == CLS_FENCE) begin
                        pc_write = 1'b1;
                    end
                end
                ST_MEM: begin
                    dmem_req   = 1'b1;
                    dmem_write = (cls == CLS_STORE);
                    pc_write   = (cls == CLS_STORE) && dmem_ready;
                end
                ST_WB: begin
                    rf_write = 1'b1;
                    pc_write = 1'b1;
                    wb_sel   = cls_wb_sel(cls);
                    pc_src   = cls_wb_pc_src(cls);
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    trap = 1'b0;
                end
            endcase
        end
    end

    assign state   = state_reg;
    assign instret = instret_reg;

endmodule
